// File: rtl/mem_arb_pkg.sv
// Shared types and default sizing for the memory-port arbiter.
package mem_arb_pkg;
  localparam int XLEN_DEF           = 32;
  localparam int ADDR_W_DEF         = 32;
  localparam int STARVE_LIMIT_DEF   = 4;
  localparam int TIMEOUT_CYCLES_DEF = 64;

  typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_WAIT} state_e;
  typedef enum logic [1:0] {OWN_NONE, OWN_IF, OWN_MA} owner_e;
endpackage

// File: rtl/mem_port_arbiter_if.sv
// Requester, memory and status signals of the arbiter; slave = arbiter side.
interface mem_port_arbiter_if #(
  parameter int XLEN   = 32,
  parameter int ADDR_W = 32
);
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_gnt;
  logic              if_rvalid;
  logic [XLEN-1:0]   if_rdata;
  logic              ma_req;
  logic              ma_we;
  logic [3:0]        ma_be;
  logic [ADDR_W-1:0] ma_addr;
  logic [XLEN-1:0]   ma_wdata;
  logic              ma_gnt;
  logic              ma_rvalid;
  logic [XLEN-1:0]   ma_rdata;
  logic              mem_req;
  logic              mem_we;
  logic [3:0]        mem_be;
  logic [ADDR_W-1:0] mem_addr;
  logic [XLEN-1:0]   mem_wdata;
  logic              mem_ready;
  logic              mem_rvalid;
  logic [XLEN-1:0]   mem_rdata;
  logic              if_stall;
  logic              ma_stall;
  logic              err;

  modport slave (
    input  if_req, if_addr, ma_req, ma_we, ma_be, ma_addr, ma_wdata,
           mem_ready, mem_rvalid, mem_rdata,
    output if_gnt, if_rvalid, if_rdata, ma_gnt, ma_rvalid, ma_rdata,
           mem_req, mem_we, mem_be, mem_addr, mem_wdata, if_stall, ma_stall, err
  );

  modport master (
    output if_req, if_addr, ma_req, ma_we, ma_be, ma_addr, ma_wdata,
           mem_ready, mem_rvalid, mem_rdata,
    input  if_gnt, if_rvalid, if_rdata, ma_gnt, ma_rvalid, ma_rdata,
           mem_req, mem_we, mem_be, mem_addr, mem_wdata, if_stall, ma_stall, err
  );
endinterface

// File: rtl/arb_watchdog.sv
// Loadable up-counter; tc_o pulses while enabled once LIMIT cycles have elapsed since load.
module arb_watchdog #(
  parameter int LIMIT = 64
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load_i,
  input  logic en_i,
  output logic tc_o
);
  localparam int CW = $clog2(LIMIT + 1);

  logic [CW-1:0] cnt_q, cnt_d;

  assign tc_o = en_i & (cnt_q == CW'(LIMIT));

  always_comb begin
    cnt_d = cnt_q;
    if (load_i)            cnt_d = '0;
    else if (en_i && !tc_o) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end
endmodule

// File: rtl/mem_port_arbiter.sv
// Single-outstanding arbiter for fetch vs load/store on one memory port, data-first with
// bounded fetch starvation. Optional watchdog under MEM_ARB_TIMEOUT_EN.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int XLEN           = XLEN_DEF,
  parameter int ADDR_W         = ADDR_W_DEF,
  parameter int STARVE_LIMIT   = STARVE_LIMIT_DEF,
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
  input logic               clk,
  input logic               rst_n,
  mem_port_arbiter_if.slave bus
);
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [SW-1:0] LIM = SW'(STARVE_LIMIT);

  state_e            state_q, state_d;
  owner_e            owner_q, owner_d;
  logic [SW-1:0]     starve_q, starve_d;
  logic              if_gnt_q, if_gnt_d, ma_gnt_q, ma_gnt_d;
  logic              we_q, we_d;
  logic [3:0]        be_q, be_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [XLEN-1:0]   wdata_q, wdata_d;
  logic              tmo, rsp, pick_if;

`ifdef MEM_ARB_TIMEOUT_EN
  arb_watchdog #(.LIMIT(TIMEOUT_CYCLES)) u_wd (
    .clk    (clk),
    .rst_n  (rst_n),
    .load_i (state_q == ST_IDLE),
    .en_i   (state_q != ST_IDLE),
    .tc_o   (tmo)
  );
`else
  logic unused_tmo;
  assign unused_tmo = ^TIMEOUT_CYCLES;
  assign tmo = 1'b0;
`endif

  // Response is only honoured in WAIT; the acceptance cycle is still ISSUE.
  assign rsp     = (state_q == ST_WAIT && bus.mem_rvalid) || tmo;
  assign pick_if = bus.if_req && (!bus.ma_req || starve_q == LIM);

  assign bus.if_gnt    = if_gnt_q;
  assign bus.ma_gnt    = ma_gnt_q;
  assign bus.if_rvalid = rsp && owner_q == OWN_IF;
  assign bus.ma_rvalid = rsp && owner_q == OWN_MA;
  assign bus.if_rdata  = (bus.if_rvalid && !tmo) ? bus.mem_rdata : '0;
  assign bus.ma_rdata  = (bus.ma_rvalid && !tmo) ? bus.mem_rdata : '0;
  assign bus.mem_req   = state_q == ST_ISSUE;
  assign bus.mem_we    = we_q;
  assign bus.mem_be    = be_q;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;
  assign bus.if_stall  = bus.if_req && !bus.if_rvalid;
  assign bus.ma_stall  = bus.ma_req && !bus.ma_rvalid;
  assign bus.err       = tmo;

  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    starve_d = starve_q;
    if_gnt_d = 1'b0;
    ma_gnt_d = 1'b0;
    we_d     = we_q;
    be_d     = be_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.if_req || bus.ma_req) begin
          state_d = ST_ISSUE;
          if (pick_if) begin
            owner_d  = OWN_IF;
            if_gnt_d = 1'b1;
            we_d     = 1'b0;
            be_d     = 4'hF;
            addr_d   = bus.if_addr;
            wdata_d  = '0;
            starve_d = '0;
          end else begin
            owner_d  = OWN_MA;
            ma_gnt_d = 1'b1;
            we_d     = bus.ma_we;
            be_d     = bus.ma_be;
            addr_d   = bus.ma_addr;
            wdata_d  = bus.ma_wdata;
            // Only a data grant that overtook a waiting fetch counts against it.
            if (!bus.if_req)         starve_d = '0;
            else if (starve_q != LIM) starve_d = starve_q + 1'b1;
          end
        end
      end
      ST_ISSUE: begin
        if (tmo) begin
          state_d = ST_IDLE;
          owner_d = OWN_NONE;
        end else if (bus.mem_ready) begin
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (rsp) begin
          state_d = ST_IDLE;
          owner_d = OWN_NONE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      owner_q  <= OWN_NONE;
      starve_q <= '0;
      if_gnt_q <= 1'b0;
      ma_gnt_q <= 1'b0;
      we_q     <= 1'b0;
      be_q     <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      starve_q <= starve_d;
      if_gnt_q <= if_gnt_d;
      ma_gnt_q <= ma_gnt_d;
      we_q     <= we_d;
      be_q     <= be_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
    end
  end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: vector table, directed corner sequences, randomized run vs model.
module tb_mem_port_arbiter;
  localparam int LIM = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  mem_port_arbiter_if #(.XLEN(32), .ADDR_W(32)) bus ();

  mem_port_arbiter #(
    .XLEN(32), .ADDR_W(32), .STARVE_LIMIT(LIM), .TIMEOUT_CYCLES(8)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic        ifr, mar, we, rdy, rv;
    logic [31:0] rd;
    logic        eig, eirv;
    logic [31:0] eird;
    logic        emg, emrv;
    logic [31:0] emrd;
    logic        ereq;
    logic [31:0] eaddr;
    logic        ewe, eis, ems;
  } vec_t;

  vec_t tbl[22];

  function automatic vec_t mk(input int ifr, mar, we, rdy, rv, rd, eig, eirv, eird,
                              emg, emrv, emrd, ereq, eaddr, ewe, eis, ems);
    vec_t v;
    v.ifr = (ifr != 0); v.mar = (mar != 0); v.we = (we != 0);
    v.rdy = (rdy != 0); v.rv = (rv != 0); v.rd = rd;
    v.eig = (eig != 0); v.eirv = (eirv != 0); v.eird = eird;
    v.emg = (emg != 0); v.emrv = (emrv != 0); v.emrd = emrd;
    v.ereq = (ereq != 0); v.eaddr = eaddr; v.ewe = (ewe != 0);
    v.eis = (eis != 0); v.ems = (ems != 0);
    return v;
  endfunction

  function automatic logic [31:0] hsh(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h5A5A1234;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic clr_in();
    bus.if_req = 0; bus.if_addr = 0; bus.ma_req = 0; bus.ma_we = 0; bus.ma_be = 0;
    bus.ma_addr = 0; bus.ma_wdata = 0; bus.mem_ready = 0; bus.mem_rvalid = 0; bus.mem_rdata = 0;
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    step();
    clr_in();
    rst_n = 0;
    step();
    step();
    rst_n = 1;
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "bench timeout");
  end

  initial begin
    int order[$];
    int exp_order[7] = '{2, 2, 2, 2, 1, 2, 2};
    int stores;
    bit pend;

    clr_in();
    do_reset();
    chk("rst_if_gnt", bus.if_gnt, 0);     chk("rst_ma_gnt", bus.ma_gnt, 0);
    chk("rst_mem_req", bus.mem_req, 0);   chk("rst_mem_addr", bus.mem_addr, 0);
    chk("rst_mem_we", bus.mem_we, 0);     chk("rst_mem_be", bus.mem_be, 0);
    chk("rst_mem_wdata", bus.mem_wdata, 0); chk("rst_err", bus.err, 0);
    chk("rst_rvalid", {bus.if_rvalid, bus.ma_rvalid}, 0);

    //              ifr mar we rdy rv rd            eig eirv eird         emg emrv emrd         ereq eaddr  ewe eis ems
    tbl[0]  = mk(1, 0, 0, 0, 0, 0,            0, 0, 0,            0, 0, 0,            0, 0,      0, 1, 0);
    tbl[1]  = mk(1, 0, 0, 1, 0, 0,            1, 0, 0,            0, 0, 0,            1, 'h100,  0, 1, 0);
    tbl[2]  = mk(1, 0, 0, 0, 1, 'h00500093,   0, 1, 'h00500093,   0, 0, 0,            0, 0,      0, 0, 0);
    tbl[3]  = mk(0, 0, 0, 0, 0, 0,            0, 0, 0,            0, 0, 0,            0, 0,      0, 0, 0);
    tbl[4]  = mk(1, 1, 0, 0, 0, 0,            0, 0, 0,            0, 0, 0,            0, 0,      0, 1, 1);
    tbl[5]  = mk(1, 1, 0, 1, 0, 0,            0, 0, 0,            1, 0, 0,            1, 'h2000, 0, 1, 1);
    tbl[6]  = mk(1, 1, 0, 0, 1, 'h11223344,   0, 0, 0,            0, 1, 'h11223344,   0, 0,      0, 1, 0);
    tbl[7]  = mk(1, 0, 0, 0, 0, 0,            0, 0, 0,            0, 0, 0,            0, 0,      0, 1, 0);
    tbl[8]  = mk(1, 0, 0, 0, 0, 0,            1, 0, 0,            0, 0, 0,            1, 'h100,  0, 1, 0);
    tbl[9]  = mk(1, 0, 0, 1, 1, 'hBAD,        0, 0, 0,            0, 0, 0,            1, 'h100,  0, 1, 0);
    tbl[10] = mk(1, 0, 0, 0, 0, 0,            0, 0, 0,            0, 0, 0,            0, 0,      0, 1, 0);
    tbl[11] = mk(1, 0, 0, 0, 1, 'h0A0B0C0D,   0, 1, 'h0A0B0C0D,   0, 0, 0,            0, 0,      0, 0, 0);
    tbl[12] = mk(0, 0, 0, 0, 1, 'h5555,       0, 0, 0,            0, 0, 0,            0, 0,      0, 0, 0);
    tbl[13] = mk(0, 1, 1, 0, 0, 0,            0, 0, 0,            0, 0, 0,            0, 0,      0, 0, 1);
    tbl[14] = mk(0, 1, 1, 0, 0, 0,            0, 0, 0,            1, 0, 0,            1, 'h2000, 1, 0, 1);
    for (int i = 15; i < 19; i++)
      tbl[i] = mk(0, 1, 1, 0, 0, 0,           0, 0, 0,            0, 0, 0,            1, 'h2000, 1, 0, 1);
    tbl[19] = mk(0, 1, 1, 1, 0, 0,            0, 0, 0,            0, 0, 0,            1, 'h2000, 1, 0, 1);
    tbl[20] = mk(0, 1, 1, 0, 1, 0,            0, 0, 0,            0, 1, 0,            0, 0,      0, 0, 0);
    tbl[21] = mk(0, 0, 0, 0, 0, 0,            0, 0, 0,            0, 0, 0,            0, 0,      0, 0, 0);

    bus.if_addr = 32'h100; bus.ma_addr = 32'h2000; bus.ma_be = 4'b0011; bus.ma_wdata = 32'hDEADBEEF;
    for (int i = 0; i < 22; i++) begin
      step();
      bus.if_req = tbl[i].ifr; bus.ma_req = tbl[i].mar; bus.ma_we = tbl[i].we;
      bus.mem_ready = tbl[i].rdy; bus.mem_rvalid = tbl[i].rv; bus.mem_rdata = tbl[i].rd;
      #1;
      chk($sformatf("v%0d_if_gnt", i), bus.if_gnt, tbl[i].eig);
      chk($sformatf("v%0d_ma_gnt", i), bus.ma_gnt, tbl[i].emg);
      chk($sformatf("v%0d_if_rvalid", i), bus.if_rvalid, tbl[i].eirv);
      chk($sformatf("v%0d_ma_rvalid", i), bus.ma_rvalid, tbl[i].emrv);
      chk($sformatf("v%0d_mem_req", i), bus.mem_req, tbl[i].ereq);
      chk($sformatf("v%0d_if_stall", i), bus.if_stall, tbl[i].eis);
      chk($sformatf("v%0d_ma_stall", i), bus.ma_stall, tbl[i].ems);
      if (tbl[i].eirv || tbl[i].emrv) begin
        chk($sformatf("v%0d_if_rdata", i), bus.if_rdata, tbl[i].eird);
        chk($sformatf("v%0d_ma_rdata", i), bus.ma_rdata, tbl[i].emrd);
      end
      if (tbl[i].ereq) begin
        chk($sformatf("v%0d_mem_addr", i), bus.mem_addr, tbl[i].eaddr);
        chk($sformatf("v%0d_mem_we", i), bus.mem_we, tbl[i].ewe);
        if (tbl[i].ewe) begin
          chk($sformatf("v%0d_mem_be", i), bus.mem_be, 32'h3);
          chk($sformatf("v%0d_mem_wdata", i), bus.mem_wdata, 32'hDEADBEEF);
        end
      end
    end

    // Six back-to-back stores against a continuously waiting fetch.
    do_reset();
    bus.if_addr = 32'h300; bus.ma_addr = 32'h4000; bus.ma_we = 1; bus.ma_be = 4'hF;
    stores = 0; pend = 0;
    for (int c = 0; c < 200 && order.size() < 7; c++) begin
      step();
      bus.if_req = 1; bus.ma_req = (stores < 6);
      bus.mem_ready = 1; bus.mem_rvalid = pend; pend = 0;
      #1;
      if (bus.mem_req) pend = 1;
      if (bus.ma_gnt) order.push_back(2);
      if (bus.if_gnt) order.push_back(1);
      if (bus.ma_rvalid) stores++;
    end
    chk("starve_grant_count", order.size(), 7);
    for (int i = 0; i < 7 && i < order.size(); i++)
      chk($sformatf("starve_order%0d", i), order[i], exp_order[i]);

    // Reset while a load sits in WAIT; the late response must vanish.
    do_reset();
    step(); bus.ma_req = 1; bus.ma_addr = 32'h2000; bus.ma_we = 0;
    step(); bus.mem_ready = 1; #1; chk("rstw_ma_gnt", bus.ma_gnt, 1);
    step(); bus.mem_ready = 0; rst_n = 0; bus.ma_req = 0;
    step(); rst_n = 1; bus.mem_rvalid = 1; bus.mem_rdata = 32'hFEED; #1;
    chk("rstw_ma_rvalid", bus.ma_rvalid, 0); chk("rstw_if_rvalid", bus.if_rvalid, 0);
    chk("rstw_ma_rdata", bus.ma_rdata, 0);   chk("rstw_mem_req", bus.mem_req, 0);
    chk("rstw_mem_addr", bus.mem_addr, 0);   chk("rstw_gnt", {bus.if_gnt, bus.ma_gnt}, 0);
    step(); bus.mem_rvalid = 0; bus.if_req = 1; bus.if_addr = 32'h180;
    step(); #1; chk("rstw_next_gnt", bus.if_gnt, 1); chk("rstw_next_addr", bus.mem_addr, 32'h180);

`ifdef MEM_ARB_TIMEOUT_EN
    do_reset();
    step(); bus.ma_req = 1; bus.ma_addr = 32'h2400; bus.ma_we = 0;
    step(); bus.mem_ready = 1; #1; chk("tmo_gnt", bus.ma_gnt, 1);
    for (int k = 1; k <= 8; k++) begin
      step(); bus.mem_ready = 0; bus.mem_rdata = 32'h1234; #1;
      chk($sformatf("tmo_rvalid_c%0d", k), bus.ma_rvalid, (k == 8));
      chk($sformatf("tmo_err_c%0d", k), bus.err, (k == 8));
      if (k == 8) chk("tmo_rdata", bus.ma_rdata, 0);
    end
    step(); bus.ma_req = 0; bus.if_req = 1; bus.if_addr = 32'h500;
    step(); bus.mem_ready = 1; #1; chk("tmo_next_gnt", bus.if_gnt, 1);
    step(); bus.mem_ready = 0; bus.mem_rvalid = 1; bus.mem_rdata = 32'h77; #1;
    chk("tmo_next_rvalid", bus.if_rvalid, 1); chk("tmo_next_rdata", bus.if_rdata, 32'h77);
    chk("tmo_next_err", bus.err, 0);
`endif

    // Randomized traffic against a transaction-level model.
    do_reset();
    begin
      int streak = 0, lat = 0, iw = 0, own = 0, exp_gnt = 0;
      bit issuing = 0, waiting = 0, f_act = 0, m_act = 0, f_rsp = 0, m_rsp = 0, rsp_now, rdy;
      logic [31:0] e_addr = 0, e_wdata = 0, f_addr = 0, m_addr = 0, m_wdata = 0;
      logic [3:0]  e_be = 0, m_be = 0;
      logic        e_we = 0, m_we = 0;
      for (int c = 0; c < 3000; c++) begin
        step();
        if (f_rsp || !f_act) begin
          f_act = ($urandom_range(0, 1) == 1);
          f_addr = $urandom & 32'hFFFF_FFFC;
        end
        if (m_rsp || !m_act) begin
          m_act = ($urandom_range(0, 1) == 1);
          m_addr = $urandom; m_wdata = $urandom;
          m_we = ($urandom_range(0, 1) == 1); m_be = 4'($urandom_range(0, 15));
        end
        bus.if_req = f_act; bus.if_addr = f_addr;
        bus.ma_req = m_act; bus.ma_addr = m_addr; bus.ma_we = m_we; bus.ma_be = m_be; bus.ma_wdata = m_wdata;
        rsp_now = waiting && lat == 0;
        rdy = (issuing && iw >= 2) ? 1'b1 : ($urandom_range(0, 1) == 1);
        bus.mem_ready = rdy;
        if (rsp_now) begin
          bus.mem_rvalid = 1; bus.mem_rdata = hsh(e_addr);
        end else begin
          bus.mem_rvalid = !waiting && ($urandom_range(0, 3) == 0);
          bus.mem_rdata = $urandom;
        end
        #1;
        chk("rnd_if_gnt", bus.if_gnt, exp_gnt == 1);
        chk("rnd_ma_gnt", bus.ma_gnt, exp_gnt == 2);
        chk("rnd_mem_req", bus.mem_req, issuing);
        if (issuing) begin
          chk("rnd_mem_addr", bus.mem_addr, e_addr);
          chk("rnd_mem_we", bus.mem_we, e_we);
          if (own == 2) begin
            chk("rnd_mem_be", bus.mem_be, e_be);
            chk("rnd_mem_wdata", bus.mem_wdata, e_wdata);
          end
        end
        chk("rnd_if_rvalid", bus.if_rvalid, rsp_now && own == 1);
        chk("rnd_ma_rvalid", bus.ma_rvalid, rsp_now && own == 2);
        if (rsp_now && own == 1) chk("rnd_if_rdata", bus.if_rdata, hsh(e_addr));
        if (rsp_now && own == 2) chk("rnd_ma_rdata", bus.ma_rdata, hsh(e_addr));
        chk("rnd_if_stall", bus.if_stall, f_act && !(rsp_now && own == 1));
        chk("rnd_ma_stall", bus.ma_stall, m_act && !(rsp_now && own == 2));
        chk("rnd_err", bus.err, 0);

        f_rsp = rsp_now && own == 1;
        m_rsp = rsp_now && own == 2;
        exp_gnt = 0;
        if (issuing) begin
          if (rdy) begin issuing = 0; waiting = 1; lat = $urandom_range(0, 3); end
          else iw++;
        end else if (waiting) begin
          if (lat == 0) begin waiting = 0; own = 0; end
          else lat--;
        end else if (f_act || m_act) begin
          if (m_act && !(f_act && streak >= LIM)) begin
            own = 2;
            streak = f_act ? ((streak < LIM) ? streak + 1 : streak) : 0;
            e_addr = m_addr; e_we = m_we; e_be = m_be; e_wdata = m_wdata;
          end else begin
            own = 1; streak = 0; e_addr = f_addr; e_we = 0;
          end
          exp_gnt = own; issuing = 1; iw = 0;
        end
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
